// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int NUM_POS = 18;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: taps 16,14,13,11 land on state bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  localparam logic [4:0] NO_PREV_IDX = 5'd31;

  // Fold a 5-bit random value onto 0..NUM_POS-1 and step past the previous mole.
  function automatic logic [4:0] pick_idx(input logic [4:0] raw, input logic [4:0] prev);
    logic [4:0] idx;
    idx = (raw >= 5'(NUM_POS)) ? raw - 5'(NUM_POS) : raw;
    if (idx == prev) begin
      idx = (idx == 5'(NUM_POS - 1)) ? 5'd0 : idx + 5'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/whack_game_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick mole positions.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else begin
      state <= {^(state & LFSR_TAP_MASK), state[15:1]};
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Round sequencer: start handshake, second timer, mole spawning and hit qualification.
module whack_game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 30,
  parameter int MOLE_CYCLES  = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic [NUM_POS-1:0] sw_pulse,
  output logic               start_pulse,
  output logic               game_active,
  output logic [NUM_POS-1:0] hit_pulse,
  output logic [NUM_POS-1:0] mole_onehot,
  output logic [7:0]         time_left,
  output logic               game_over
);

  localparam int SEC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int LIFE_W = $clog2(MOLE_CYCLES);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(CLK_HZ - 1);
  localparam logic [LIFE_W-1:0] LIFE_LOAD = LIFE_W'(MOLE_CYCLES - 1);

  game_state_t        state_reg, state_next;
  logic               start_btn_q;
  logic [SEC_W-1:0]   sec_reg;
  logic [LIFE_W-1:0]  life_reg;
  logic [7:0]         time_left_reg;
  logic [NUM_POS-1:0] mole_reg;
  logic [NUM_POS-1:0] hit_reg;
  logic [4:0]         prev_idx_reg;
  logic [15:0]        lfsr_state;

  logic               start_edge;
  logic               sec_wrap;
  logic               final_tick;
  logic [NUM_POS-1:0] hit_vec;
  logic [4:0]         spawn_idx;
  logic               unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr_state)
  );

  assign start_edge       = start_btn & ~start_btn_q;
  assign sec_wrap         = (state_reg == PLAY) && (sec_reg == SEC_LAST);
  assign final_tick       = sec_wrap && (time_left_reg == 8'd1);
  assign hit_vec          = (state_reg == PLAY) ? (sw_pulse & mole_reg) : '0;
  assign spawn_idx        = pick_idx(lfsr_state[4:0], prev_idx_reg);
  assign unused_lfsr_bits = ^lfsr_state[15:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, OVER: if (start_edge) state_next = ARM;
      ARM:        state_next = PLAY;
      PLAY:       if (final_tick) state_next = OVER;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_btn_q   <= 1'b0;
      sec_reg       <= '0;
      life_reg      <= '0;
      time_left_reg <= '0;
      mole_reg      <= '0;
      hit_reg       <= '0;
      prev_idx_reg  <= NO_PREV_IDX;
    end else begin
      start_btn_q <= start_btn;
      hit_reg     <= hit_vec;
      case (state_reg)
        ARM: begin
          time_left_reg <= 8'(GAME_SECONDS);
          sec_reg       <= '0;
          life_reg      <= '0;
          mole_reg      <= '0;
          prev_idx_reg  <= NO_PREV_IDX;
        end
        PLAY: begin
          if (sec_wrap) begin
            sec_reg       <= '0;
            time_left_reg <= time_left_reg - 8'd1;
          end else begin
            sec_reg <= sec_reg + SEC_W'(1);
          end
          // A hit takes priority over the lifetime expiring on the same edge.
          if (final_tick || (|hit_vec)) begin
            mole_reg <= '0;
          end else if (mole_reg == '0) begin
            mole_reg     <= NUM_POS'(1) << spawn_idx;
            prev_idx_reg <= spawn_idx;
            life_reg     <= LIFE_LOAD;
          end else if (life_reg == '0) begin
            mole_reg <= '0;
          end else begin
            life_reg <= life_reg - LIFE_W'(1);
          end
        end
        OVER: mole_reg <= '0;
        default: ;
      endcase
    end
  end

  assign start_pulse = (state_reg == ARM);
  assign game_active = (state_reg == PLAY);
  assign game_over   = (state_reg == OVER);
  assign hit_pulse   = hit_reg;
  assign mole_onehot = mole_reg;
  assign time_left   = time_left_reg;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Randomised self-checking bench for whack_game_ctrl against a round-level reference model.
module tb_whack_game_ctrl;

  localparam int CLK_HZ = 10;
  localparam int GS     = 3;
  localparam int MC     = 8;
  localparam int ROUND  = GS * CLK_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_btn = 1'b0;
  logic [17:0] sw_pulse = '0;
  logic        start_pulse, game_active, game_over;
  logic [17:0] hit_pulse, mole_onehot;
  logic [7:0]  time_left;

  always #5 clk = ~clk;

  whack_game_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .GAME_SECONDS (GS),
    .MOLE_CYCLES  (MC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .sw_pulse    (sw_pulse),
    .start_pulse (start_pulse),
    .game_active (game_active),
    .hit_pulse   (hit_pulse),
    .mole_onehot (mole_onehot),
    .time_left   (time_left),
    .game_over   (game_over)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase of the round, PLAY cycles elapsed, lit mole index and its age.
  typedef enum {M_IDLE, M_ARM, M_PLAY, M_OVER} mphase_t;
  mphase_t     m_phase;
  int          m_play_cnt, m_mole, m_age, m_prev;
  logic [7:0]  m_time;
  logic [17:0] m_hit;
  logic [15:0] m_lfsr;
  logic        m_btn_q;

  logic [17:0] last_lit, prev_vis;
  int          sp_count;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  task automatic model_reset();
    m_phase    = M_IDLE;
    m_play_cnt = 0;
    m_mole     = -1;
    m_age      = 0;
    m_prev     = 31;
    m_time     = '0;
    m_hit      = '0;
    m_lfsr     = 16'hACE1;
    m_btn_q    = 1'b0;
    last_lit   = '0;
    prev_vis   = '0;
  endtask

  task automatic model_edge();
    logic start_edge, hit;
    int   idx;
    start_edge = start_btn && !m_btn_q;
    m_btn_q    = start_btn;
    m_hit      = '0;
    case (m_phase)
      M_IDLE, M_OVER: if (start_edge) m_phase = M_ARM;
      M_ARM: begin
        m_phase = M_PLAY; m_play_cnt = 0; m_mole = -1; m_prev = 31; m_time = 8'(GS);
      end
      M_PLAY: begin
        hit = (m_mole >= 0) && sw_pulse[m_mole];
        if (hit) m_hit = 18'(1) << m_mole;
        m_play_cnt++;
        if (m_play_cnt == ROUND) begin
          m_phase = M_OVER; m_mole = -1; m_time = '0;
        end else begin
          m_time = 8'(GS - m_play_cnt / CLK_HZ);
          if (hit) begin
            m_mole = -1;
          end else if (m_mole < 0) begin
            idx = int'(m_lfsr & 16'h001F) % 18;
            if (idx == m_prev) idx = (idx + 1) % 18;
            m_mole = idx; m_prev = idx; m_age = 0;
          end else begin
            m_age++;
            if (m_age == MC) m_mole = -1;
          end
        end
      end
      default: ;
    endcase
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [17:0] exp_mole;
    exp_mole = (m_mole >= 0) ? (18'(1) << m_mole) : '0;
    check("start_pulse", 32'(start_pulse), 32'(m_phase == M_ARM));
    check("game_active", 32'(game_active), 32'(m_phase == M_PLAY));
    check("game_over",   32'(game_over),   32'(m_phase == M_OVER));
    check("time_left",   32'(time_left),   32'(m_time));
    check("mole_onehot", 32'(mole_onehot), 32'(exp_mole));
    check("hit_pulse",   32'(hit_pulse),   32'(m_hit));
    if (start_pulse) sp_count++;
    if (!rst_n || start_pulse) begin
      last_lit = '0;
    end else if (mole_onehot != '0 && prev_vis == '0) begin
      if (last_lit != '0) check("mole_changes", 32'(mole_onehot == last_lit), 32'd0);
      last_lit = mole_onehot;
    end
    prev_vis = mole_onehot;
    $display("t=%0t st=%0d sp=%0b act=%0b ovr=%0b tl=%0d mole=%05h sw=%05h hit=%05h",
             $time, m_phase, start_pulse, game_active, game_over, time_left,
             mole_onehot, sw_pulse, hit_pulse);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  // mode 1: press only on expiry / final-tick edges; 2: random; 3: unlit noise only.
  task automatic drive_sw(input int mode);
    logic [17:0] lit, noise;
    lit      = (m_mole >= 0) ? (18'(1) << m_mole) : '0;
    noise    = 18'($urandom) & ~lit;
    sw_pulse = '0;
    case (mode)
      1: if (m_phase == M_PLAY && (m_age == MC - 1 || m_play_cnt == ROUND - 1)) sw_pulse = lit;
      2: case ($urandom_range(0, 3))
           0: sw_pulse = lit;
           1: sw_pulse = noise;
           2: sw_pulse = lit | noise;
           default: ;
         endcase
      3: if ($urandom_range(0, 1) == 1) sw_pulse = noise;
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    sp_count = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Start held for the whole round; hits only on expiry and final-tick edges.
    start_btn = 1'b1;
    sp_count  = 0;
    for (int i = 0; i < ROUND + 6; i++) begin
      drive_sw(1);
      tick();
    end
    sw_pulse = '0;
    check("one_start_pulse", 32'(sp_count), 32'd1);
    check("over_after_hold", 32'(game_over), 32'd1);

    // Restart from OVER, random presses and start-button chatter during play.
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    for (int i = 0; i < ROUND + 6; i++) begin
      drive_sw(2);
      if (m_phase == M_PLAY) start_btn = 1'($urandom_range(0, 1));
      else start_btn = 1'b0;
      tick();
    end

    // Restart, then an asynchronous reset in the middle of play.
    start_btn = 1'b0;
    sw_pulse  = '0;
    tick();
    start_btn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive_sw(2);
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick();
    rst_n     = 1'b1;
    start_btn = 1'b0;
    sw_pulse  = '0;
    tick();

    // Untouched moles must time out; presses on unlit positions must be ignored.
    start_btn = 1'b1;
    for (int i = 0; i < ROUND + 5; i++) begin
      drive_sw(3);
      tick();
    end
    sw_pulse = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
